// File: rtl/tt_sel_seq_pkg.sv
// Shared types for the design-selection sequencer.
package tt_sel_seq_pkg;

  // Sequencer phases; 3-bit binary encoding.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRstLo = 3'd1,
    StGap   = 3'd2,
    StIncHi = 3'd3,
    StIncLo = 3'd4,
    StEna   = 3'd5
  } sel_state_e;

endpackage

// File: rtl/tt_sel_seq_timer.sv
// Loadable phase down-counter; tick flags the last cycle of a phase.
module tt_sel_seq_timer #(
  parameter int unsigned PW_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PW_W-1:0] load_val,
  output logic            tick
);

  logic [PW_W-1:0] cnt_q;

  // Reload on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/tt_sel_seq.sv
// Replays the pad protocol that selects a user design: reset the selection
// counter, issue addr increment pulses, then re-enable.
module tt_sel_seq
  import tt_sel_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned PW     = 4,
  parameter int unsigned PW_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  localparam logic [PW_W-1:0] PhaseLoad = PW_W'(PW - 1);

  sel_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_left_q, cnt_left_d;
  logic              tick;
  logic              load;
  logic              accept;
  logic              ctrl_ena_d;

  assign accept = req_valid & req_ready;

  tt_sel_seq_timer #(
    .PW_W (PW_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (PhaseLoad),
    .tick     (tick)
  );

  // Next-state logic; every state change reloads the shared phase timer.
  always_comb begin
    state_d    = state_q;
    cnt_left_d = cnt_left_q;
    load       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StRstLo;
          cnt_left_d = req_addr;
          load       = 1'b1;
        end
      end
      StRstLo: begin
        if (tick) begin
          state_d = StGap;
          load    = 1'b1;
        end
      end
      StGap: begin
        if (tick) begin
          state_d = (cnt_left_q == '0) ? StEna : StIncHi;
          load    = 1'b1;
        end
      end
      StIncHi: begin
        if (tick) begin
          state_d = StIncLo;
          load    = 1'b1;
          // Count the pulse as it ends; guard keeps cnt_left from wrapping.
          if (cnt_left_q != '0) begin
            cnt_left_d = cnt_left_q - 1'b1;
          end
        end
      end
      StIncLo: begin
        if (tick) begin
          state_d = (cnt_left_q == '0) ? StEna : StIncHi;
          load    = 1'b1;
        end
      end
      StEna: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Enable holds through idle after a completed sequence; a new accept clears it.
  always_comb begin
    ctrl_ena_d = (state_d == StEna) | (ctrl_ena & (state_d == StIdle));
  end

  // State and output registers; outputs decode the next state so pads are flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_left_q     <= '0;
      req_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      ctrl_sel_rst_n <= 1'b1;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_left_q     <= cnt_left_d;
      req_ready      <= (state_d == StIdle);
      busy           <= (state_d != StIdle);
      done           <= (state_d == StEna);
      ctrl_sel_rst_n <= (state_d != StRstLo);
      ctrl_sel_inc   <= (state_d == StIncHi);
      ctrl_ena       <= ctrl_ena_d;
    end
  end

endmodule

// File: tb/tb_tt_sel_seq.sv
// Bench for tt_sel_seq: two instances (PW=2 and PW=1) checked every cycle
// against a timeline model of the pad protocol, plus a selection-counter
// scoreboard and literal timing checks on the first sequence of each.
module tb_tt_sel_seq;

  localparam int unsigned AW  = 10;
  localparam int unsigned PWW = 8;
  localparam int          BOUND = 5000;

  function automatic int pw_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [2];
  logic          req_valid [2];
  logic [AW-1:0] req_addr  [2];
  logic          req_ready [2];
  logic          busy      [2];
  logic          done      [2];
  logic          rstn_o    [2];
  logic          inc_o     [2];
  logic          ena_o     [2];

  tt_sel_seq #(.ADDR_W(AW), .PW(2), .PW_W(PWW)) u_dut_pw2 (
    .clk            (clk),
    .rst            (rst[0]),
    .req_valid      (req_valid[0]),
    .req_addr       (req_addr[0]),
    .req_ready      (req_ready[0]),
    .busy           (busy[0]),
    .done           (done[0]),
    .ctrl_sel_rst_n (rstn_o[0]),
    .ctrl_sel_inc   (inc_o[0]),
    .ctrl_ena       (ena_o[0])
  );

  tt_sel_seq #(.ADDR_W(AW), .PW(1), .PW_W(PWW)) u_dut_pw1 (
    .clk            (clk),
    .rst            (rst[1]),
    .req_valid      (req_valid[1]),
    .req_addr       (req_addr[1]),
    .req_ready      (req_ready[1]),
    .busy           (busy[1]),
    .done           (done[1]),
    .ctrl_sel_rst_n (rstn_o[1]),
    .ctrl_sel_inc   (inc_o[1]),
    .ctrl_ena       (ena_o[1])
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int d, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t: got %0d, expected %0d", name, d, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name, input int d);
    tests++;
    fails++;
    $display("FAIL %s dut%0d t=%0t: timed out after %0d cycles", name, d, $time, BOUND);
  endtask

  // Model: a sequence is a timeline indexed by j = edges since the accept edge.
  int cyc = 0;
  bit seq     [2] = '{0, 0};
  int t_acc   [2];
  int a_m     [2];
  bit ena_m   [2] = '{0, 0};
  bit rdy_prev[2] = '{1, 1};
  int nseq    [2] = '{0, 0};
  bit e_rdy [2], e_rstn [2], e_inc [2], e_done [2], e_ena [2];
  int sel_cnt [2] = '{0, 0};
  bit inc_prev[2] = '{0, 0};
  bit ena_prev[2] = '{0, 0};
  bit h_inc [2][64];
  bit h_rstn[2][64];
  bit h_done[2][64];
  bit h_rdy [2][64];

  // Compare process: update model at the edge, check DUT 1 time unit later.
  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      int pw, len, j;
      pw = pw_of(d);
      if (rst[d]) begin
        seq[d]   = 1'b0;
        ena_m[d] = 1'b0;
      end else if (req_valid[d] && rdy_prev[d]) begin
        seq[d]   = 1'b1;
        t_acc[d] = cyc;
        a_m[d]   = int'(req_addr[d]);
        ena_m[d] = 1'b0;
        nseq[d]++;
      end
      len = 2 * pw * (1 + a_m[d]);
      j   = cyc - t_acc[d];
      if (seq[d] && j > len) begin
        seq[d]   = 1'b0;
        ena_m[d] = 1'b1;
      end
      if (seq[d]) begin
        e_rdy[d]  = 1'b0;
        e_rstn[d] = !(j < pw);
        e_inc[d]  = (j >= 2 * pw) && (j < len) && ((j % (2 * pw)) < pw);
        e_done[d] = (j == len);
        e_ena[d]  = (j == len);
      end else begin
        e_rdy[d]  = 1'b1;
        e_rstn[d] = 1'b1;
        e_inc[d]  = 1'b0;
        e_done[d] = 1'b0;
        e_ena[d]  = ena_m[d];
      end
      rdy_prev[d] = e_rdy[d];
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      int j;
      chk("req_ready", d, int'(req_ready[d]), int'(e_rdy[d]));
      chk("busy", d, int'(busy[d]), int'(!e_rdy[d]));
      chk("done", d, int'(done[d]), int'(e_done[d]));
      chk("ctrl_sel_rst_n", d, int'(rstn_o[d]), int'(e_rstn[d]));
      chk("ctrl_sel_inc", d, int'(inc_o[d]), int'(e_inc[d]));
      chk("ctrl_ena", d, int'(ena_o[d]), int'(e_ena[d]));
      // On-chip selection counter as the pads would drive it.
      if (!rstn_o[d]) sel_cnt[d] = 0;
      else if (inc_o[d] && !inc_prev[d]) sel_cnt[d]++;
      if (ena_o[d] && !ena_prev[d]) chk("sel_count_at_ena", d, sel_cnt[d], a_m[d]);
      inc_prev[d] = inc_o[d];
      ena_prev[d] = ena_o[d];
      j = cyc - t_acc[d];
      if (nseq[d] == 1 && j >= 0 && j < 64) begin
        h_inc[d][j]  = inc_o[d];
        h_rstn[d][j] = rstn_o[d];
        h_done[d][j] = done[d];
        h_rdy[d][j]  = req_ready[d];
      end
    end
  end

  // Present a request and hold it until accepted; drop valid afterwards.
  task automatic do_req(input int d, input int addr);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_addr[d]  = AW'(addr);
    n = 0;
    while (!req_ready[d] && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) timeout_fail("accept", d);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) timeout_fail("idle", d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d]       = 1'b1;
      req_valid[d] = 1'b0;
      req_addr[d]  = '0;
    end
    // Reset together with a pending request: reset must win.
    req_valid[0] = 1'b1;
    req_addr[0]  = AW'(5);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", d, int'(req_ready[d]), 1);
      chk("reset_rstn", d, int'(rstn_o[d]), 1);
      chk("reset_ena", d, int'(ena_o[d]), 0);
      chk("reset_inc", d, int'(inc_o[d]), 0);
      rst[d] = 1'b0;
    end
    req_valid[0] = 1'b0;
    chk("reset_no_accept", 0, nseq[0], 0);

    // PW=2, addr=3, with addr=7 presented while busy.
    do_req(0, 3);
    req_valid[0] = 1'b1;
    req_addr[0]  = AW'(7);
    do_req(0, 7);
    wait_idle(0);
    chk("busy_req_seq_count", 0, nseq[0], 2);
    chk("pw2_rstn_T1", 0, int'(h_rstn[0][0]), 0);
    chk("pw2_rstn_T2", 0, int'(h_rstn[0][1]), 0);
    chk("pw2_rstn_T3", 0, int'(h_rstn[0][2]), 1);
    chk("pw2_inc_T4", 0, int'(h_inc[0][3]), 0);
    chk("pw2_inc_T5", 0, int'(h_inc[0][4]), 1);
    chk("pw2_inc_T6", 0, int'(h_inc[0][5]), 1);
    chk("pw2_inc_T7", 0, int'(h_inc[0][6]), 0);
    chk("pw2_inc_T9", 0, int'(h_inc[0][8]), 1);
    chk("pw2_inc_T14", 0, int'(h_inc[0][13]), 1);
    chk("pw2_inc_T15", 0, int'(h_inc[0][14]), 0);
    chk("pw2_done_T16", 0, int'(h_done[0][15]), 0);
    chk("pw2_done_T17", 0, int'(h_done[0][16]), 1);
    chk("pw2_ready_T17", 0, int'(h_rdy[0][16]), 0);
    chk("pw2_ready_T18", 0, int'(h_rdy[0][17]), 1);
    chk("ena_held_idle", 0, int'(ena_o[0]), 1);

    // Randomized requests on PW=2, including back-to-back.
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      do_req(0, $urandom_range(0, 12));
    end
    wait_idle(0);

    // Reset while the second increment pulse is high.
    begin
      int pulses, n;
      bit prev;
      do_req(0, 5);
      pulses = 0;
      prev   = 1'b0;
      n      = 0;
      while (pulses < 2 && n < BOUND) begin
        @(negedge clk);
        if (inc_o[0] && !prev) pulses++;
        prev = inc_o[0];
        n++;
      end
      if (n >= BOUND) timeout_fail("second_pulse", 0);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      chk("midrst_inc", 0, int'(inc_o[0]), 0);
      chk("midrst_rstn", 0, int'(rstn_o[0]), 1);
      chk("midrst_ena", 0, int'(ena_o[0]), 0);
      chk("midrst_done", 0, int'(done[0]), 0);
      chk("midrst_ready", 0, int'(req_ready[0]), 1);
      repeat (6) @(negedge clk);
    end

    // PW=1: addr=0, then full-scale address, then a few random ones.
    do_req(1, 0);
    wait_idle(1);
    chk("pw1_a0_done_T2", 1, int'(h_done[1][1]), 0);
    chk("pw1_a0_done_T3", 1, int'(h_done[1][2]), 1);
    chk("pw1_a0_ready_T4", 1, int'(h_rdy[1][3]), 1);
    for (int j = 0; j < 5; j++) chk("pw1_a0_no_inc", 1, int'(h_inc[1][j]), 0);
    do_req(1, 1023);
    wait_idle(1);
    chk("pw1_full_scale_cnt", 1, sel_cnt[1], 1023);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(1, $urandom_range(0, 40));
    end
    wait_idle(1);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
